// File: rtl/addsub_pipe.sv
// Signed add/sub/accumulate unit with a two-slice valid/ready pipeline.
// Optional saturation, per-result overflow and a sticky overflow flag.
module addsub_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sat,
    input  logic [WIDTH-1:0] Rd1,
    input  logic [WIDTH-1:0] Rd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e              op_sel;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_sel, sum, diff, clamp;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d, ovf_add, ovf_sub;
    logic             s1_valid_q, s1_ovf_q;
    logic [WIDTH-1:0] s1_res_q;
    logic             s2_valid_q, s2_ovf_q;
    logic [WIDTH-1:0] s2_res_q;
    logic             sticky_q;
    logic             s2_load, accept;

    assign op_sel = op_e'(op);

    // ACC adds Rd1 to the accumulator; everything else uses Rd2
    assign b_sel   = (op_sel == OP_ACC) ? acc_q : Rd2;
    assign sum     = Rd1 + b_sel;
    assign diff    = Rd1 - Rd2;
    assign ovf_add = (Rd1[M] == b_sel[M]) && (sum[M] != Rd1[M]);
    assign ovf_sub = (Rd1[M] != Rd2[M]) && (diff[M] != Rd1[M]);
    // Overflow direction always follows the sign of Rd1
    assign clamp   = Rd1[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        acc_d = acc_q;
        unique case (op_sel)
            OP_ADD, OP_ACC: begin
                ovf_d = ovf_add;
                res_d = (ovf_add && sat) ? clamp : sum;
            end
            OP_SUB: begin
                ovf_d = ovf_sub;
                res_d = (ovf_sub && sat) ? clamp : diff;
            end
            OP_CLR: begin
                ovf_d = 1'b0;
                res_d = '0;
            end
        endcase
        if (!en) begin
            res_d = '0;
            ovf_d = 1'b0;
        end else if (op_sel == OP_ACC || op_sel == OP_CLR) begin
            acc_d = res_d;
        end
    end

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_ovf_q   <= 1'b0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_res_q <= res_d;
                    s1_ovf_q <= ovf_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_q <= s1_res_q;
                    s2_ovf_q <= s1_ovf_q;
                end
            end
            if (accept) begin
                acc_q <= acc_d;
            end
            // A delivered overflow beats a simultaneous clear
            if (s2_valid_q && out_ready && s2_ovf_q) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign result     = s2_res_q;
    assign overflow   = s2_ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=4): vector table plus
// hand-written latency, accumulate, backpressure, sticky and reset cases.
module tb_addsub_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic       sat;
    logic [3:0] Rd1, Rd2;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       overflow;
    logic       ovf_sticky;
    logic       clr_sticky;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] op;
        logic       sat;
        logic       en;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [3:0] res;
        logic       ovf;
        int         cyc;
    } obs_t;

    vec_t tv[18];
    obs_t q[$];

    addsub_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sat       (sat),
        .Rd1       (Rd1),
        .Rd2       (Rd2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .ovf_sticky(ovf_sticky),
        .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q.push_back('{res: result, ovf: overflow, cyc: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic s,
                         input logic e, input logic [3:0] a,
                         input logic [3:0] b);
        op       = o;
        sat      = s;
        en       = e;
        Rd1      = a;
        Rd2      = b;
        in_valid = 1'b1;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic s, input logic e,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] r, input logic v);
        int lat;
        drive(o, s, e, a, b);
        #1;
        chk({nm, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 6) begin
            tick();
            lat++;
        end
        chk({nm, "_lat"}, lat, 1);
        chk({nm, "_res"}, result, r);
        chk({nm, "_ovf"}, overflow, v);
        tick();
    endtask

    initial begin
        tv[0]  = '{2'b00, 1'b0, 1'b1, 4'h7, 4'h1, 4'h8, 1'b1};
        tv[1]  = '{2'b00, 1'b1, 1'b1, 4'h7, 4'h1, 4'h7, 1'b1};
        tv[2]  = '{2'b01, 1'b1, 1'b1, 4'h8, 4'h1, 4'h8, 1'b1};
        tv[3]  = '{2'b01, 1'b1, 1'b1, 4'h3, 4'h5, 4'he, 1'b0};
        tv[4]  = '{2'b00, 1'b0, 1'b1, 4'h2, 4'h3, 4'h5, 1'b0};
        tv[5]  = '{2'b01, 1'b0, 1'b1, 4'h8, 4'h1, 4'h7, 1'b1};
        tv[6]  = '{2'b00, 1'b1, 1'b1, 4'h8, 4'hf, 4'h8, 1'b1};
        tv[7]  = '{2'b00, 1'b0, 1'b1, 4'h8, 4'hf, 4'h7, 1'b1};
        tv[8]  = '{2'b11, 1'b0, 1'b1, 4'h9, 4'h9, 4'h0, 1'b0};
        tv[9]  = '{2'b10, 1'b0, 1'b1, 4'h5, 4'h0, 4'h5, 1'b0};
        tv[10] = '{2'b10, 1'b0, 1'b0, 4'h7, 4'h0, 4'h0, 1'b0};
        tv[11] = '{2'b10, 1'b0, 1'b1, 4'h0, 4'h0, 4'h5, 1'b0};
        tv[12] = '{2'b10, 1'b1, 1'b1, 4'h5, 4'h0, 4'h7, 1'b1};
        tv[13] = '{2'b10, 1'b0, 1'b1, 4'h1, 4'h0, 4'h8, 1'b1};
        tv[14] = '{2'b11, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[15] = '{2'b10, 1'b0, 1'b1, 4'h0, 4'h0, 4'h8, 1'b0};
        tv[16] = '{2'b11, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[17] = '{2'b00, 1'b0, 1'b0, 4'h7, 4'h1, 4'h0, 1'b0};

        rst_n      = 1'b0;
        en         = 1'b0;
        in_valid   = 1'b0;
        op         = 2'b00;
        sat        = 1'b0;
        Rd1        = '0;
        Rd2        = '0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sticky", ovf_sticky, 0);

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("tv%0d", i), tv[i].op, tv[i].sat, tv[i].en,
                   tv[i].a, tv[i].b, tv[i].res, tv[i].ovf);
        end
        chk("tbl_sticky", ovf_sticky, 1);

        // sticky: clear alone, then clear racing an overflowed delivery
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("stk_clear", ovf_sticky, 0);
        drive(2'b00, 1'b0, 1'b1, 4'h7, 4'h1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("stk_valid", out_valid, 1);
        chk("stk_ovf", overflow, 1);
        chk("stk_pre", ovf_sticky, 0);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("stk_set_wins", ovf_sticky, 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("stk_clr_alone", ovf_sticky, 0);

        // back-to-back accumulate
        q.delete();
        drive(2'b11, 1'b0, 1'b1, 4'h0, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1'b0, 1'b1, 4'h3, 4'h0);
            #1;
            chk($sformatf("acc%0d_rdy", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("acc_count", q.size(), 4);
        if (q.size() == 4) begin
            chk("acc0_res", q[0].res, 4'h0);
            chk("acc1_res", q[1].res, 4'h3);
            chk("acc1_ovf", q[1].ovf, 0);
            chk("acc2_res", q[2].res, 4'h6);
            chk("acc2_ovf", q[2].ovf, 0);
            chk("acc3_res", q[3].res, 4'h9);
            chk("acc3_ovf", q[3].ovf, 1);
            chk("acc_consec", q[3].cyc - q[1].cyc, 2);
        end

        // backpressure: two ops buffer, third waits
        q.delete();
        out_ready = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 4'h1, 4'h1);
        #1;
        chk("bp_rdy0", in_ready, 1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 4'h2, 4'h2);
        #1;
        chk("bp_rdy1", in_ready, 1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 4'h3, 4'h3);
        #1;
        chk("bp_full", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d_rdy", i), in_ready, 0);
            chk($sformatf("bp_hold%0d_res", i), result, 4'h2);
            chk($sformatf("bp_hold%0d_vld", i), out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", q.size(), 3);
        if (q.size() == 3) begin
            chk("bp_out0", q[0].res, 4'h2);
            chk("bp_out1", q[1].res, 4'h4);
            chk("bp_out2", q[2].res, 4'h6);
        end

        // reset with two ops in flight
        run_op("pre_clr", 2'b11, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        run_op("pre_acc", 2'b10, 1'b0, 1'b1, 4'h5, 4'h0, 4'h5, 1'b0);
        q.delete();
        out_ready = 1'b0;
        drive(2'b00, 1'b0, 1'b1, 4'h1, 4'h1);
        tick();
        drive(2'b00, 1'b0, 1'b1, 4'h2, 4'h2);
        tick();
        in_valid = 1'b0;
        chk("mid_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_res", result, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("mid_no_stale", q.size(), 0);
        chk("mid_rdy", in_ready, 1);
        run_op("mid_acc0", 2'b10, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
